pipe_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 5-stage OpenMIPS core (pc_reg, if_id, id_ex, ex_mem, mem_wb).

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_ctrl_wdog.sv | 42 ++++
 rtl/pipe_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller: stall vectors,
// controller states and the request-stall priority function.
package pipe_ctrl_pkg;

    localparam int REG_W = 32;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;
    localparam logic [5:0] STALL_ALL  = 6'b111111;

    typedef enum logic [1:0] {
        CTRL_RUN    = 2'd0,
        CTRL_FREEZE = 2'd1,
        CTRL_FLUSH  = 2'd2,
        CTRL_DRAIN  = 2'd3
    } ctrl_state_e;

    // The latest stage asking to hold wins: it must freeze everything behind it.
    function automatic logic [5:0] stall_req_vec(input logic id, input logic ex, input logic mem);
        if (mem)     return STALL_MEM;
        else if (ex) return STALL_EX;
        else if (id) return STALL_ID;
        else         return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_wdog.sv
// Consecutive request-stall run counter with a sticky watchdog flag.
module ctrl_wdog #(
    parameter  int LIMIT = 1024,
    localparam int CW    = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          clr_i,
    output logic [CW-1:0] cnt_o,
    output logic          wdog_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          wdog_q, wdog_d;

    always_comb begin
        cnt_d  = cnt_q;
        wdog_d = wdog_q;
        if (clr_i)
            cnt_d = '0;
        else if (stall_i && cnt_q != CW'(LIMIT))
            cnt_d = cnt_q + 1'b1;
        // Flag on the same edge the counter lands on the limit.
        if (LIMIT != 0 && cnt_d == CW'(LIMIT))
            wdog_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            wdog_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wdog_q <= wdog_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign wdog_o = wdog_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: merges stage stall requests and sequences
// exception freeze/flush/redirect/drain, with a stall counter and watchdog.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 1,
    parameter int WDOG_LIMIT   = 1024,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             excp_valid_i,
    input  logic [REG_W-1:0] excp_pc_i,
    output logic [5:0]       stall_o,
    output logic             flush_o,
    output logic [REG_W-1:0] new_pc_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             wdog_o
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int RW = (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT + 1) : 1;

    ctrl_state_e      state_q, state_d;
    logic [DW-1:0]    drain_q, drain_d;
    logic [REG_W-1:0] excp_pc_q, excp_pc_d;
    logic [REG_W-1:0] new_pc_q, new_pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [5:0]       req_vec, stall_d;
    logic             flush_d, req_stall;
    logic [RW-1:0]    run_cnt;

    assign req_vec = stall_req_vec(stallreq_id, stallreq_ex, stallreq_mem);

    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        excp_pc_d = excp_pc_q;
        stall_d   = STALL_NONE;
        flush_d   = 1'b0;
        req_stall = 1'b0;
        unique case (state_q)
            CTRL_RUN: begin
                if (excp_valid_i) begin
                    stall_d   = STALL_ALL;
                    excp_pc_d = excp_pc_i;
                    state_d   = CTRL_FREEZE;
                end else begin
                    stall_d   = req_vec;
                    req_stall = req_vec[0];
                end
            end
            CTRL_FREEZE: begin
                stall_d = STALL_ALL;
                state_d = CTRL_FLUSH;
            end
            CTRL_FLUSH: begin
                flush_d = 1'b1;
                drain_d = DW'(DRAIN_CYCLES - 1);
                state_d = CTRL_DRAIN;
            end
            CTRL_DRAIN: begin
                stall_d   = req_vec;
                req_stall = req_vec[0];
                if (drain_q == '0)
                    state_d = CTRL_RUN;
                else
                    drain_d = drain_q - 1'b1;
            end
            default: state_d = CTRL_RUN;
        endcase
    end

    // Redirect target is registered so it appears exactly in the FLUSH cycle.
    assign new_pc_d    = (state_d == CTRL_FLUSH) ? excp_pc_q : '0;
    assign stall_cnt_d = stall_cnt_q + CNT_W'(req_stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CTRL_RUN;
            drain_q     <= '0;
            excp_pc_q   <= '0;
            new_pc_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            excp_pc_q   <= excp_pc_d;
            new_pc_q    <= new_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    ctrl_wdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .stall_i (req_stall),
        .clr_i   (~stall_d[0] | flush_d),
        .cnt_o   (run_cnt),
        .wdog_o  (wdog_o)
    );

    assign stall_o     = stall_d;
    assign flush_o     = flush_d;
    assign new_pc_o    = new_pc_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (WDOG_LIMIT=8, CNT_W=4).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_id = 1'b0, stallreq_ex = 1'b0, stallreq_mem = 1'b0;
    logic        excp_valid_i = 1'b0;
    logic [31:0] excp_pc_i = '0;
    logic [5:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic [3:0]  stall_cnt_o;
    logic        wdog_o;

    int checks = 0;
    int failures = 0;

    pipe_ctrl #(.DRAIN_CYCLES(1), .WDOG_LIMIT(8), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excp_valid_i (excp_valid_i),
        .excp_pc_i    (excp_pc_i),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .new_pc_o     (new_pc_o),
        .stall_cnt_o  (stall_cnt_o),
        .wdog_o       (wdog_o)
    );

    always #5 clk = ~clk;

    // Inputs change 1 unit after the rising edge; outputs are checked 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0; excp_valid_i = 0; excp_pc_i = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (stall_o !== 6'b0 || flush_o !== 1'b0 || new_pc_o !== 32'h0 ||
            stall_cnt_o !== 4'h0 || wdog_o !== 1'b0) begin
            failures++;
            $display("FAIL reset_state stall=%b flush=%b pc=%h cnt=%0d wdog=%b expected all zero",
                     stall_o, flush_o, new_pc_o, stall_cnt_o, wdog_o);
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_priority();
        do_reset();
        step(); stallreq_id = 1; settle();
        checks++; if (stall_o !== 6'b000111) begin failures++; $display("FAIL prio_id got=%b exp=000111", stall_o); end
        step(); stallreq_ex = 1; settle();
        checks++; if (stall_o !== 6'b001111) begin failures++; $display("FAIL prio_ex got=%b exp=001111", stall_o); end
        step(); stallreq_mem = 1; settle();
        checks++; if (stall_o !== 6'b011111) begin failures++; $display("FAIL prio_mem got=%b exp=011111", stall_o); end
        step(); stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0; settle();
        checks++; if (stall_o !== 6'b000000) begin failures++; $display("FAIL prio_none got=%b exp=000000", stall_o); end
        checks++; if (stall_cnt_o !== 4'd3) begin failures++; $display("FAIL prio_cnt got=%0d exp=3", stall_cnt_o); end
    endtask

    task automatic test_exception();
        do_reset();
        step(); excp_valid_i = 1; excp_pc_i = 32'h0000_0040; settle();
        checks++; if (stall_o !== 6'b111111 || flush_o !== 1'b0) begin failures++; $display("FAIL excp_n stall=%b flush=%b exp 111111/0", stall_o, flush_o); end
        step(); excp_valid_i = 0; excp_pc_i = '0; settle();
        checks++; if (stall_o !== 6'b111111 || flush_o !== 1'b0) begin failures++; $display("FAIL excp_freeze stall=%b flush=%b exp 111111/0", stall_o, flush_o); end
        step(); settle();
        checks++; if (flush_o !== 1'b1 || stall_o !== 6'b0 || new_pc_o !== 32'h40) begin failures++; $display("FAIL excp_flush flush=%b stall=%b pc=%h exp 1/000000/40", flush_o, stall_o, new_pc_o); end
        step(); stallreq_ex = 1; settle();
        checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'h0 || stall_o !== 6'b001111) begin failures++; $display("FAIL excp_drain flush=%b pc=%h stall=%b exp 0/0/001111", flush_o, new_pc_o, stall_o); end
        // In RUN a new exception is accepted again, unlike in DRAIN.
        step(); stallreq_ex = 0; excp_valid_i = 1; excp_pc_i = 32'h0000_0050; settle();
        checks++; if (stall_o !== 6'b111111) begin failures++; $display("FAIL excp_back_in_run stall=%b exp=111111", stall_o); end
        step(); excp_valid_i = 0; step(); settle();
        checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h50) begin failures++; $display("FAIL excp_second_flush flush=%b pc=%h exp 1/50", flush_o, new_pc_o); end
    endtask

    task automatic test_excp_over_stall();
        do_reset();
        step(); excp_valid_i = 1; stallreq_mem = 1; excp_pc_i = 32'h0000_0060; settle();
        checks++; if (stall_o !== 6'b111111) begin failures++; $display("FAIL excp_wins stall=%b exp=111111", stall_o); end
        step(); excp_valid_i = 0; stallreq_mem = 0; settle();
        checks++; if (stall_cnt_o !== 4'd0) begin failures++; $display("FAIL excp_no_cnt got=%0d exp=0", stall_cnt_o); end
        step(); settle();
        checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h60) begin failures++; $display("FAIL excp_wins_flush flush=%b pc=%h exp 1/60", flush_o, new_pc_o); end
        step(); excp_valid_i = 1; excp_pc_i = 32'h0000_0080; settle();
        checks++; if (stall_o !== 6'b0 || flush_o !== 1'b0) begin failures++; $display("FAIL drain_ignore stall=%b flush=%b exp 000000/0", stall_o, flush_o); end
        step(); excp_valid_i = 0; excp_pc_i = '0; settle();
        checks++; if (stall_o !== 6'b0 || flush_o !== 1'b0) begin failures++; $display("FAIL drain_ignore_n4 stall=%b flush=%b exp 000000/0", stall_o, flush_o); end
        step(); settle();
        checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'h0) begin failures++; $display("FAIL drain_ignore_n5 flush=%b pc=%h exp 0/0", flush_o, new_pc_o); end
        checks++; if (stall_cnt_o !== 4'd0) begin failures++; $display("FAIL excp_cnt_end got=%0d exp=0", stall_cnt_o); end
    endtask

    task automatic test_watchdog();
        do_reset();
        step(); stallreq_ex = 1;
        repeat (7) step();
        checks++; if (wdog_o !== 1'b0) begin failures++; $display("FAIL wdog_early got=%b exp=0", wdog_o); end
        step();
        checks++; if (wdog_o !== 1'b1) begin failures++; $display("FAIL wdog_set got=%b exp=1", wdog_o); end
        stallreq_ex = 0;
        step(); step();
        checks++; if (wdog_o !== 1'b1) begin failures++; $display("FAIL wdog_sticky got=%b exp=1", wdog_o); end
        rst = 1'b1; settle();
        checks++; if (wdog_o !== 1'b0) begin failures++; $display("FAIL wdog_rst got=%b exp=0", wdog_o); end
        step(); rst = 1'b0;
        // A broken run (gap of one cycle) must restart the count from zero.
        stallreq_id = 1; repeat (5) step();
        stallreq_id = 0; step();
        stallreq_id = 1; repeat (7) step();
        checks++; if (wdog_o !== 1'b0) begin failures++; $display("FAIL wdog_run_clear got=%b exp=0", wdog_o); end
        step();
        checks++; if (wdog_o !== 1'b1) begin failures++; $display("FAIL wdog_run_restart got=%b exp=1", wdog_o); end
        stallreq_id = 0;
    endtask

    task automatic test_reset_mid_flush();
        do_reset();
        step(); excp_valid_i = 1; excp_pc_i = 32'h0000_0070;
        step(); excp_valid_i = 0; excp_pc_i = '0;
        step(); settle();
        checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h70) begin failures++; $display("FAIL midrst_pre flush=%b pc=%h exp 1/70", flush_o, new_pc_o); end
        rst = 1'b1; settle();
        checks++; if (flush_o !== 1'b0 || new_pc_o !== 32'h0) begin failures++; $display("FAIL midrst_async flush=%b pc=%h exp 0/0", flush_o, new_pc_o); end
        step(); rst = 1'b0;
        step(); excp_valid_i = 1; excp_pc_i = 32'h0000_0100; settle();
        checks++; if (stall_o !== 6'b111111) begin failures++; $display("FAIL midrst_run stall=%b exp=111111", stall_o); end
        step(); excp_valid_i = 0; excp_pc_i = '0; settle();
        checks++; if (flush_o !== 1'b0) begin failures++; $display("FAIL midrst_freeze flush=%b exp=0", flush_o); end
        step(); settle();
        checks++; if (flush_o !== 1'b1 || new_pc_o !== 32'h100) begin failures++; $display("FAIL midrst_flush flush=%b pc=%h exp 1/100", flush_o, new_pc_o); end
    endtask

    task automatic test_wrap();
        do_reset();
        step(); stallreq_id = 1;
        repeat (16) step();
        checks++; if (stall_cnt_o !== 4'd0) begin failures++; $display("FAIL wrap_16 got=%0d exp=0", stall_cnt_o); end
        step(); stallreq_id = 0;
        checks++; if (stall_cnt_o !== 4'd1) begin failures++; $display("FAIL wrap_17 got=%0d exp=1", stall_cnt_o); end
        step();
        checks++; if (stall_cnt_o !== 4'd1) begin failures++; $display("FAIL wrap_hold got=%0d exp=1", stall_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_exception();
        test_excp_over_stall();
        test_watchdog();
        test_reset_mid_flush();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
